pcm_output_buffer: RTL and testbench
====================================

// Module: pcm_output_buffer
// PURPOSE
//  512-entry stereo PCM sample buffer between the MPEG audio synthesis stage and ac97_ctr.
//  Decoder pushes 16-bit L/R sample pairs; ac97_ctr pulls them by 9-bit read address,
//  gated by PCM_READ_ADVANCE_EN_O. Handles priming, underrun muting and pointer realignment.
// PARAMETERS
//  PRIME_LEVEL   128  samples buffered before playback (re)starts; legal 1..512
//  MUTE_ON_STALL 1    1: CH*_PCM_DATA_O forced to 0 outside PLAY; 0: RAM data always shown
// PORTS
//  BIT_CLOCK_I             in  1   AC97 bit clock, sole clock
//  AC97_RESETN_I           in  1   reset, asynchronous, active-low
//  FLUSH_I                 in  1   sync flush: discard contents, realign, re-prime
//  PCM_WR_EN_I             in  1   push one sample pair (ignored when PCM_FULL_O=1)
//  PCM_WR_CH0_I            in  16  left sample, two's complement
//  PCM_WR_CH1_I            in  16  right sample
//  PCM_FULL_O              out 1   level==512
//  PCM_READ_ADDRESS_I      in  9   ac97_ctr read pointer
//  PCM_READ_ADVANCE_EN_O   out 1   permits ac97_ctr to advance its pointer
//  CH0_PCM_DATA_O          out 16  left sample at current read address
//  CH1_PCM_DATA_O          out 16  right sample at current read address
//  PCM_LEVEL_O             out 10  occupancy 0..512
//  UNDERRUN_COUNT_O        out 8   underrun events, saturating at 255
//  OVERFLOW_O              out 1   sticky: push attempted while full; cleared by reset/flush
// BEHAVIOUR
//  Reset: wr_ptr=0, addr_q=0, level=0, state=ALIGN; all outputs 0.
//  Storage: 512x32 RAM {CH0,CH1}; write at wr_ptr, read at PCM_READ_ADDRESS_I, 1-cycle reg latency.
//  Pop detect: addr_q <= PCM_READ_ADDRESS_I each cycle; pop = (PCM_READ_ADDRESS_I != addr_q).
//   ac97_ctr advances at most +1 per 250 clocks, so any change counts as exactly one pop.
//  Push = PCM_WR_EN_I & ~PCM_FULL_O; wr_ptr +1 mod 512 (511->0 wraps).
//  Level: push&~pop +1; pop&~push -1; both -> unchanged; pop at level 0 ignored (no wrap).
//  Push while full: dropped, wr_ptr/level unchanged, OVERFLOW_O<=1.
//  FSM:
//   ALIGN   : 1 cycle; wr_ptr<=PCM_READ_ADDRESS_I, addr_q<=PCM_READ_ADDRESS_I, level<=0,
//             OVERFLOW_O<=0, push ignored; -> PRIME. (ac97_ctr pointer is not reset by us;
//             alignment keeps reset/flush mid-stream from producing spurious pops.)
//   PRIME   : ADVANCE_EN=0; -> PLAY when level >= PRIME_LEVEL (checked on registered level).
//   PLAY    : ADVANCE_EN=(level!=0); if level reaches 0 -> UNDERRUN.
//   UNDERRUN: 1 cycle; UNDERRUN_COUNT_O +1 (sat. 255); ADVANCE_EN=0; -> PRIME.
//  FLUSH_I=1 in any state: next state ALIGN (takes priority over push/pop that cycle).
//  ADVANCE_EN and PCM_FULL_O registered, derived from next-state level/state (no comb path).
//  MUTE_ON_STALL=1: CH*_PCM_DATA_O=0 in ALIGN/PRIME/UNDERRUN, RAM data in PLAY.
// TESTING
//  Reset, no writes, drive ADDR_I=0 -> ADVANCE_EN=0, CH*=0, LEVEL=0, state PRIME after 1 clk.
//  Push 128 pairs (0x0001..0x0080 / inverted) -> ADVANCE_EN=1 one cycle after 128th push;
//   ADDR_I=0 -> CH0=0x0001 next cycle; step ADDR_I 0..127 -> 127 pops, LEVEL=1 at end.
//  Push 512 pairs no pops -> PCM_FULL_O=1, LEVEL=512; 513th push -> dropped, OVERFLOW_O=1.
//  Prime then drain to 0 -> ADVANCE_EN=0, UNDERRUN_COUNT_O=1, CH*=0; 128 more pushes -> PLAY.
//  wr_ptr at 510, push 4 -> wraps to 2; reads at 510,511,0,1 return pushed data in order.
//  Mid-PLAY assert FLUSH_I (or reset) with ADDR_I=0x1A3 -> LEVEL=0, no pop counted,
//   next push lands at 0x1A3; simultaneous push+pop in PLAY -> LEVEL unchanged.

Source files
------------

// File: rtl/pcm_output_buffer.sv
// 512x{L,R} PCM buffer between synthesis and ac97_ctr; primes, mutes on underrun, realigns on flush.
// Read data 1 cycle after address; pushes dropped (sticky OVERFLOW_O) when full, ac97_ctr gated by ADVANCE_EN.
module pcm_output_buffer #(
  parameter int PRIME_LEVEL   = 128,
  parameter bit MUTE_ON_STALL = 1'b1
) (
  input  logic        BIT_CLOCK_I,
  input  logic        AC97_RESETN_I,
  input  logic        FLUSH_I,
  input  logic        PCM_WR_EN_I,
  input  logic [15:0] PCM_WR_CH0_I,
  input  logic [15:0] PCM_WR_CH1_I,
  output logic        PCM_FULL_O,
  input  logic [8:0]  PCM_READ_ADDRESS_I,
  output logic        PCM_READ_ADVANCE_EN_O,
  output logic [15:0] CH0_PCM_DATA_O,
  output logic [15:0] CH1_PCM_DATA_O,
  output logic [9:0]  PCM_LEVEL_O,
  output logic [7:0]  UNDERRUN_COUNT_O,
  output logic        OVERFLOW_O
);

  typedef enum logic [1:0] {
    ALIGN    = 2'd0,
    PRIME    = 2'd1,
    PLAY     = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  localparam logic [9:0] PRIME_LVL = 10'(PRIME_LEVEL);

  logic [31:0] mem [512];
  logic [31:0] rd_q;
  logic [8:0]  wr_ptr_q;
  logic [8:0]  addr_q;
  logic [9:0]  level_q;
  logic [9:0]  level_nxt;
  state_t      state_q;
  state_t      state_nxt;
  logic        active;
  logic        push;
  logic        pop;
  logic        show;

  // Flush and the alignment cycle both freeze the pointers, so no push or pop is seen.
  assign active = !FLUSH_I && (state_q != ALIGN);
  assign push   = active && PCM_WR_EN_I && !PCM_FULL_O;
  assign pop    = active && (PCM_READ_ADDRESS_I != addr_q) && (level_q != 10'd0);

  always_comb begin
    state_nxt = state_q;
    level_nxt = level_q;
    if (FLUSH_I) begin
      state_nxt = ALIGN;
      level_nxt = 10'd0;
    end else if (state_q == ALIGN) begin
      state_nxt = PRIME;
      level_nxt = 10'd0;
    end else begin
      if (push && !pop) begin
        level_nxt = level_q + 10'd1;
      end else if (pop && !push) begin
        level_nxt = level_q - 10'd1;
      end
      case (state_q)
        PRIME:    if (level_q >= PRIME_LVL) state_nxt = PLAY;
        PLAY:     if (level_nxt == 10'd0) state_nxt = UNDERRUN;
        UNDERRUN: state_nxt = PRIME;
        default:  state_nxt = state_q;
      endcase
    end
  end

  always_ff @(posedge BIT_CLOCK_I) begin
    if (push) begin
      mem[wr_ptr_q] <= {PCM_WR_CH0_I, PCM_WR_CH1_I};
    end
  end

  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    if (!AC97_RESETN_I) begin
      state_q               <= ALIGN;
      level_q               <= 10'd0;
      wr_ptr_q              <= 9'd0;
      addr_q                <= 9'd0;
      rd_q                  <= 32'd0;
      PCM_FULL_O            <= 1'b0;
      PCM_READ_ADVANCE_EN_O <= 1'b0;
      UNDERRUN_COUNT_O      <= 8'd0;
      OVERFLOW_O            <= 1'b0;
    end else begin
      state_q               <= state_nxt;
      level_q               <= level_nxt;
      addr_q                <= PCM_READ_ADDRESS_I;
      rd_q                  <= mem[PCM_READ_ADDRESS_I];
      PCM_FULL_O            <= (level_nxt == 10'd512);
      PCM_READ_ADVANCE_EN_O <= (state_nxt == PLAY) && (level_nxt != 10'd0);

      // Writes resume exactly where ac97_ctr is reading, whatever its pointer was.
      if (!FLUSH_I && state_q == ALIGN) begin
        wr_ptr_q <= PCM_READ_ADDRESS_I;
      end else if (push) begin
        wr_ptr_q <= wr_ptr_q + 9'd1;
      end

      if (FLUSH_I || state_q == ALIGN) begin
        OVERFLOW_O <= 1'b0;
      end else if (PCM_WR_EN_I && PCM_FULL_O) begin
        OVERFLOW_O <= 1'b1;
      end

      if (state_q == PLAY && state_nxt == UNDERRUN && UNDERRUN_COUNT_O != 8'hFF) begin
        UNDERRUN_COUNT_O <= UNDERRUN_COUNT_O + 8'd1;
      end
    end
  end

  assign show           = !MUTE_ON_STALL || (state_q == PLAY);
  assign CH0_PCM_DATA_O = show ? rd_q[31:16] : 16'd0;
  assign CH1_PCM_DATA_O = show ? rd_q[15:0]  : 16'd0;
  assign PCM_LEVEL_O    = level_q;

endmodule

// File: tb/tb_pcm_output_buffer.sv
// Randomized bench for pcm_output_buffer: buffer model plus read-data scoreboard.
module tb_pcm_output_buffer;

  logic        BIT_CLOCK_I = 1'b0;
  logic        AC97_RESETN_I;
  logic        FLUSH_I;
  logic        PCM_WR_EN_I;
  logic [15:0] PCM_WR_CH0_I;
  logic [15:0] PCM_WR_CH1_I;
  logic        PCM_FULL_O;
  logic [8:0]  PCM_READ_ADDRESS_I;
  logic        PCM_READ_ADVANCE_EN_O;
  logic [15:0] CH0_PCM_DATA_O;
  logic [15:0] CH1_PCM_DATA_O;
  logic [9:0]  PCM_LEVEL_O;
  logic [7:0]  UNDERRUN_COUNT_O;
  logic        OVERFLOW_O;

  pcm_output_buffer #(.PRIME_LEVEL(128), .MUTE_ON_STALL(1'b1)) dut (
    .BIT_CLOCK_I           (BIT_CLOCK_I),
    .AC97_RESETN_I         (AC97_RESETN_I),
    .FLUSH_I               (FLUSH_I),
    .PCM_WR_EN_I           (PCM_WR_EN_I),
    .PCM_WR_CH0_I          (PCM_WR_CH0_I),
    .PCM_WR_CH1_I          (PCM_WR_CH1_I),
    .PCM_FULL_O            (PCM_FULL_O),
    .PCM_READ_ADDRESS_I    (PCM_READ_ADDRESS_I),
    .PCM_READ_ADVANCE_EN_O (PCM_READ_ADVANCE_EN_O),
    .CH0_PCM_DATA_O        (CH0_PCM_DATA_O),
    .CH1_PCM_DATA_O        (CH1_PCM_DATA_O),
    .PCM_LEVEL_O           (PCM_LEVEL_O),
    .UNDERRUN_COUNT_O      (UNDERRUN_COUNT_O),
    .OVERFLOW_O            (OVERFLOW_O)
  );

  always #5 BIT_CLOCK_I = ~BIT_CLOCK_I;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  // Reference buffer: contents by address, occupancy, pointers, event counts.
  logic [31:0] m_mem [512];
  int          m_level = 0;
  int          m_wr    = 0;
  int          m_addr  = 0;
  int          m_under = 0;
  bit          m_ovf   = 1'b0;

  always @(posedge BIT_CLOCK_I) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // One clock of stimulus; the model applies the buffer rules to what was driven.
  task automatic cycle(input bit we, input logic [15:0] d0, input logic [15:0] d1,
                       input int a, input bit chk_rd);
    bit          do_push;
    bit          do_pop;
    bit          collide;
    logic [31:0] ed;
    PCM_WR_EN_I        = we;
    PCM_WR_CH0_I       = d0;
    PCM_WR_CH1_I       = d1;
    PCM_READ_ADDRESS_I = 9'(a);
    do_push = we && (m_level != 512);
    do_pop  = (a != m_addr) && (m_level != 0);
    collide = do_push && (m_wr == a);
    if (we && m_level == 512) m_ovf = 1'b1;
    if (do_push) begin
      m_mem[m_wr] = {d0, d1};
      m_wr = (m_wr + 1) % 512;
    end
    m_level = m_level + int'(do_push) - int'(do_pop);
    if (do_pop && m_level == 0 && m_under < 255) m_under++;
    m_addr = a;
    ed = (m_level != 0) ? m_mem[a] : 32'h0;
    @(posedge BIT_CLOCK_I);
    #1;
    if (chk_rd && !collide) exp_q.push_back('{cyc, ed});
    PCM_WR_EN_I = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 16'h0, m_addr, 1'b0);
  endtask

  task automatic flush_to(input int a);
    FLUSH_I            = 1'b1;
    PCM_WR_EN_I        = 1'b0;
    PCM_READ_ADDRESS_I = 9'(a);
    @(posedge BIT_CLOCK_I);
    #1;
    FLUSH_I = 1'b0;
    @(posedge BIT_CLOCK_I);
    #1;
    m_level = 0;
    m_wr    = a;
    m_addr  = a;
    m_ovf   = 1'b0;
  endtask

  task automatic wait_adv(input string name);
    int n;
    n = 0;
    while (!PCM_READ_ADVANCE_EN_O && n < 20) begin
      idle();
      n++;
    end
    chk(name, 32'(PCM_READ_ADVANCE_EN_O), 32'd1);
  endtask

  always @(negedge BIT_CLOCK_I) begin
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("rd_ch0", 32'(CH0_PCM_DATA_O), 32'(mon_e.dat[31:16]));
      chk("rd_ch1", 32'(CH1_PCM_DATA_O), 32'(mon_e.dat[15:0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int wp [3] = '{30, 65, 95};
  int ap [3] = '{60, 50, 20};
  int plen [3] = '{700, 700, 1500};
  bit r_we;
  bit r_adv;

  initial begin
    AC97_RESETN_I      = 1'b0;
    FLUSH_I            = 1'b0;
    PCM_WR_EN_I        = 1'b0;
    PCM_WR_CH0_I       = 16'h0;
    PCM_WR_CH1_I       = 16'h0;
    PCM_READ_ADDRESS_I = 9'h0;
    repeat (3) @(posedge BIT_CLOCK_I);
    #1;
    chk("rst_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);
    chk("rst_ch0", 32'(CH0_PCM_DATA_O), 32'd0);
    chk("rst_ch1", 32'(CH1_PCM_DATA_O), 32'd0);
    chk("rst_level", 32'(PCM_LEVEL_O), 32'd0);
    chk("rst_full", 32'(PCM_FULL_O), 32'd0);
    chk("rst_under", 32'(UNDERRUN_COUNT_O), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW_O), 32'd0);
    AC97_RESETN_I = 1'b1;
    idle();
    chk("align_level", 32'(PCM_LEVEL_O), 32'd0);
    chk("align_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);

    // Prime with the ramp, play it out, drain to underrun, then re-prime.
    for (int i = 0; i < 128; i++) cycle(1'b1, 16'(i + 1), ~16'(i + 1), 0, 1'b0);
    chk("prime_level", 32'(PCM_LEVEL_O), 32'd128);
    chk("prime_adv_early", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);
    idle();
    chk("prime_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd1);
    for (int a = 0; a < 128; a++) cycle(1'b0, 16'h0, 16'h0, a, 1'b1);
    chk("play_level", 32'(PCM_LEVEL_O), 32'd1);
    chk("play_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd1);
    cycle(1'b0, 16'h0, 16'h0, 128, 1'b1);
    chk("drain_level", 32'(PCM_LEVEL_O), 32'd0);
    chk("drain_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);
    chk("drain_under", 32'(UNDERRUN_COUNT_O), 32'(m_under));
    idle();
    chk("mute_ch0", 32'(CH0_PCM_DATA_O), 32'd0);
    chk("mute_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);
    for (int i = 0; i < 128; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 128, 1'b0);
    wait_adv("reprime_adv");
    cycle(1'b0, 16'h0, 16'h0, 128, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 129, 1'b1);
    chk("reprime_level", 32'(PCM_LEVEL_O), 32'd127);

    // Flush mid-play to a foreign pointer, fill to full, overflow, then push+pop together.
    flush_to(9'h1A3);
    chk("flush_level", 32'(PCM_LEVEL_O), 32'd0);
    chk("flush_adv", 32'(PCM_READ_ADVANCE_EN_O), 32'd0);
    chk("flush_under", 32'(UNDERRUN_COUNT_O), 32'(m_under));
    for (int i = 0; i < 512; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 9'h1A3, 1'b0);
    chk("full_flag", 32'(PCM_FULL_O), 32'd1);
    chk("full_level", 32'(PCM_LEVEL_O), 32'd512);
    chk("full_ovf_clear", 32'(OVERFLOW_O), 32'd0);
    cycle(1'b1, 16'($urandom), 16'($urandom), 9'h1A3, 1'b0);
    chk("ovf_set", 32'(OVERFLOW_O), 32'd1);
    chk("ovf_level", 32'(PCM_LEVEL_O), 32'd512);
    cycle(1'b0, 16'h0, 16'h0, 9'h1A3, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 9'h1A4, 1'b1);
    chk("pop_level", 32'(PCM_LEVEL_O), 32'd511);
    cycle(1'b1, 16'($urandom), 16'($urandom), 9'h1A5, 1'b1);
    chk("pushpop_level", 32'(PCM_LEVEL_O), 32'd511);

    // Pointer wrap: align at 510 so writes and reads both cross 511->0.
    flush_to(510);
    chk("flush_ovf", 32'(OVERFLOW_O), 32'd0);
    for (int i = 0; i < 128; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 510, 1'b0);
    wait_adv("wrap_adv");
    cycle(1'b0, 16'h0, 16'h0, 510, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 511, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 0, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 2, 1'b1);
    chk("wrap_level", 32'(PCM_LEVEL_O), 32'd124);

    // Random traffic: ac97_ctr steps only when permitted; rates swing from starved to full.
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < plen[ph]; k++) begin
        r_we  = ($urandom_range(99) < wp[ph]);
        r_adv = PCM_READ_ADVANCE_EN_O && ($urandom_range(99) < ap[ph]);
        cycle(r_we, 16'($urandom), 16'($urandom), r_adv ? (m_addr + 1) % 512 : m_addr, r_adv);
        chk("rnd_level", 32'(PCM_LEVEL_O), 32'(m_level));
        chk("rnd_full", 32'(PCM_FULL_O), 32'(m_level == 512));
        chk("rnd_ovf", 32'(OVERFLOW_O), 32'(m_ovf));
      end
    end
    idle();
    idle();
    chk("end_under", 32'(UNDERRUN_COUNT_O), 32'(m_under));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
